state_machine: RTL and testbench

STATE_MACHINE -- requirements
Module: state_machine

---
 rtl/state_machine_pkg.sv | 22 ++
 rtl/state_machine_dwell_timer.sv | 40 ++++
 rtl/state_machine.sv | 54 +++++
 tb/tb_state_machine.sv | 100 ++++++++++
 4 files changed

// File: rtl/state_machine_pkg.sv
// Shared types and helpers for the four-state sequencer.
package state_machine_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   // Successor of cur in the configured direction; wraps naturally in 2 bits.
   function automatic state_t next_state(state_t cur, bit down);
      logic [STATE_W-1:0] v;
      v = cur;
      if (down) v = v - 2'd1;
      else      v = v + 2'd1;
      return state_t'(v);
   endfunction

endpackage

// File: rtl/state_machine_dwell_timer.sv
// Dwell timer: counts cycles spent in the current state and raises tick
// for one cycle on the last dwell cycle. Optional checks under
// STATE_MACHINE_ASSERT_EN.
module state_machine_dwell_timer
   import state_machine_pkg::*;
#(
   parameter int DWELL_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (DWELL_CYCLES < 2) ? 1 : $clog2(DWELL_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear on the last dwell cycle (or any out-of-range value),
   // otherwise increment.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q >= LAST) cnt_d = '0;
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

`ifdef STATE_MACHINE_ASSERT_EN
   // The counter must never reach DWELL_CYCLES.
   a_cnt_range: assert property (@(posedge clk)
      !$isunknown(cnt_q) |-> (int'(cnt_q) < DWELL_CYCLES));
`endif

endmodule

// File: rtl/state_machine.sv
// Four-state sequencer S0..S3 that advances one step every DWELL_CYCLES
// clocks, up or down depending on COUNT_DOWN. Defining
// STATE_MACHINE_ASSERT_EN adds concurrent and elaboration-time checks.
module state_machine
   import state_machine_pkg::*;
#(
   parameter int   DWELL_CYCLES = 1,
   parameter logic COUNT_DOWN   = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   output logic [STATE_W-1:0] state
);

   state_t state_q, state_d;
   logic   tick;

   state_machine_dwell_timer #(
      .DWELL_CYCLES(DWELL_CYCLES)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Next state: hold unless the dwell timer signals the last cycle.
   always_comb begin
      state_d = state_q;
      if (tick) state_d = next_state(state_q, COUNT_DOWN);
   end

   // State register; reset takes priority over any pending advance.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S0;
      else     state_q <= state_d;
   end

   assign state = STATE_W'(state_q);

`ifdef STATE_MACHINE_ASSERT_EN
   if (DWELL_CYCLES < 1 || DWELL_CYCLES > 65535) begin : g_bad_param
      $error("state_machine: DWELL_CYCLES out of range 1..65535");
   end

   // A reset edge always leaves the machine in S0.
   a_rst_s0: assert property (@(posedge clk) rst |=> (state_q == S0));

   // Outside reset the state either holds or moves to its successor.
   a_step: assert property (@(posedge clk)
      (!$past(rst) && !$isunknown($past(state_q)) && (state_q != $past(state_q)))
      |-> (state_q == next_state($past(state_q), COUNT_DOWN)));
`endif

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine: dwell 1 counting up, dwell 1 counting
// down, and dwell 3 counting up, each with its own reset.
module tb_state_machine;

   logic       clk;
   logic       rst1, rstd, rst3;
   logic [1:0] st1, std, st3;

   int n_chk;
   int n_err;

   state_machine #(.DWELL_CYCLES(1), .COUNT_DOWN(1'b0)) u_d1 (
      .clk(clk), .rst(rst1), .state(st1));
   state_machine #(.DWELL_CYCLES(1), .COUNT_DOWN(1'b1)) u_dn (
      .clk(clk), .rst(rstd), .state(std));
   state_machine #(.DWELL_CYCLES(3), .COUNT_DOWN(1'b0)) u_d3 (
      .clk(clk), .rst(rst3), .state(st3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst1 = 1'b1; rstd = 1'b1; rst3 = 1'b1;

      // Reset held for two edges: everything sits in S0.
      step();
      chk("rst1_d1", st1, 2'd0); chk("rst1_dn", std, 2'd0); chk("rst1_d3", st3, 2'd0);
      step();
      chk("rst2_d1", st1, 2'd0); chk("rst2_dn", std, 2'd0); chk("rst2_d3", st3, 2'd0);

      // 20 free-running edges: five wraps for dwell 1, three-edge holds for dwell 3.
      rst1 = 1'b0; rstd = 1'b0; rst3 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk("run_d1", st1, 2'(i % 4));
         chk("run_dn", std, 2'((4 - (i % 4)) % 4));
         chk("run_d3", st3, 2'((i / 3) % 4));
      end

      // Dwell 3: reset pulse while in S2 at dwell count 1.
      rst3 = 1'b1; step(); chk("d3_rstA", st3, 2'd0);
      rst3 = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk("d3_toS2", st3, 2'((i / 3) % 4));
      end
      rst3 = 1'b1; step(); chk("d3_midrst", st3, 2'd0);
      rst3 = 1'b0;
      step(); chk("d3_hold1", st3, 2'd0);
      step(); chk("d3_hold2", st3, 2'd0);
      step(); chk("d3_adv", st3, 2'd1);

      // Dwell 3: reset on the edge where the S3->S0 wrap is due.
      rst3 = 1'b1; step(); chk("d3_rstB", st3, 2'd0);
      rst3 = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         step();
         chk("d3_toS3", st3, 2'((i / 3) % 4));
      end
      rst3 = 1'b1; step(); chk("d3_wraprst", st3, 2'd0);
      rst3 = 1'b0;
      step(); chk("d3_w_hold1", st3, 2'd0);
      step(); chk("d3_w_hold2", st3, 2'd0);
      step(); chk("d3_w_adv", st3, 2'd1);

      // Dwell 1 up/down: reset against a due wrap in each direction.
      rst1 = 1'b1; rstd = 1'b1; step();
      chk("d1_rstC", st1, 2'd0); chk("dn_rstC", std, 2'd0);
      rst1 = 1'b0; rstd = 1'b0;
      step(); chk("c1_d1", st1, 2'd1); chk("c1_dn", std, 2'd3);
      step(); chk("c2_d1", st1, 2'd2); chk("c2_dn", std, 2'd2);
      step(); chk("c3_d1", st1, 2'd3); chk("c3_dn", std, 2'd1);
      rst1 = 1'b1;
      step(); chk("d1_wraprst", st1, 2'd0); chk("c4_dn", std, 2'd0);
      rst1 = 1'b0; rstd = 1'b1;
      step(); chk("d1_after", st1, 2'd1); chk("dn_wraprst", std, 2'd0);
      rstd = 1'b0;
      step(); chk("d1_c6", st1, 2'd2); chk("dn_after", std, 2'd3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
